// File: rtl/fifo_in_unpack_pkg.sv
// Shared definitions for the packer/unpacker pair: chunk widths, buffer sizing and FSM encoding.
package fifo_in_unpack_pkg;

   localparam int DATA_W   = 64;
   localparam int NARROW_W = 48;
   localparam int BUF_W    = 2 * DATA_W;
   localparam int IDX_W    = $clog2(BUF_W + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int countOnes(input logic [31:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/unpack_buffer.sv
// Two-word shift/insert buffer: valid bits sit LSB-aligned below index, and everything above index is zero.
module unpack_buffer
   import fifo_in_unpack_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              insert,
   input  logic [DATA_W-1:0] insData,
   input  logic              pop,
   input  logic              narrow,
   output logic [DATA_W-1:0] head,
   output logic [IDX_W-1:0]  index
);

   logic [BUF_W-1:0] bufData;
   logic [BUF_W-1:0] shifted;
   logic [IDX_W-1:0] chunkW;
   logic [IDX_W-1:0] popAmt;
   logic [IDX_W-1:0] idxAfter;

   // The pop is applied first so a word arriving in the same cycle lands right above the surviving bits.
   always_comb begin
      chunkW   = narrow ? IDX_W'(NARROW_W) : IDX_W'(DATA_W);
      popAmt   = (index < chunkW) ? index : chunkW;
      shifted  = bufData;
      idxAfter = index;
      if (pop) begin
         shifted  = bufData >> chunkW;
         idxAfter = index - popAmt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bufData <= '0;
         index   <= '0;
      end else if (insert) begin
         bufData <= shifted | ({{DATA_W{1'b0}}, insData} << idxAfter);
         index   <= idxAfter + IDX_W'(DATA_W);
      end else begin
         bufData <= shifted;
         index   <= idxAfter;
      end
   end

   assign head = bufData[DATA_W-1:0];

endmodule

// File: rtl/fifo_in_unpack.sv
// Reads a run of packed DRAM words and unpacks them into a valid/ready stream of wide or narrow chunks,
// zero-padding the tail chunk when the bit count is not a chunk multiple.
module fifo_in_unpack
   import fifo_in_unpack_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] baseAddr,
   input  logic [ADDR_W-1:0] numWords,
   input  logic              chunkSel,
   output logic              DRAMreadEn,
   output logic [ADDR_W-1:0] DRAMreadAddr,
   input  logic [DATA_W-1:0] DRAMreadData,
   output logic [DATA_W-1:0] outData,
   output logic              outValid,
   input  logic              outReady,
   output logic              outLast,
   output logic              busy,
   output logic              done
);

   localparam logic [DATA_W-1:0] NARROW_MASK = {{(DATA_W-NARROW_W){1'b0}}, {NARROW_W{1'b1}}};

   logic [1:0]        state;
   logic [ADDR_W-1:0] baseReg;
   logic [ADDR_W:0]   numReg;
   logic [ADDR_W:0]   wordsIssued;
   logic [ADDR_W:0]   wordsRecv;
   logic              narrowReg;
   logic [RD_LAT-1:0] inflight;
   logic [DATA_W-1:0] head;
   logic [IDX_W-1:0]  index;
   logic [IDX_W-1:0]  chunkW;
   logic [15:0]       fillNeed;
   logic              arrive;
   logic              allRecv;
   logic              insert;
   logic              pop;

   assign arrive  = inflight[RD_LAT-1];
   assign insert  = arrive && (state == ST_RUN);
   assign allRecv = (wordsRecv == numReg);
   assign chunkW  = narrowReg ? IDX_W'(NARROW_W) : IDX_W'(DATA_W);
   assign pop     = outValid && outReady;

   // A read is only issued if the buffer can hold it plus every word already in flight.
   assign fillNeed     = 16'(index) + 16'(DATA_W * (countOnes(32'(inflight)) + 1));
   assign DRAMreadEn   = (state == ST_RUN) && (wordsIssued < numReg) && (fillNeed <= 16'(BUF_W));
   assign DRAMreadAddr = baseReg + wordsIssued[ADDR_W-1:0];

   assign outData = narrowReg ? (head & NARROW_MASK) : head;
   assign busy    = (state == ST_RUN) || (state == ST_FLUSH);
   assign done    = (state == ST_DONE);

   always_comb begin
      outValid = 1'b0;
      outLast  = 1'b0;
      case (state)
         ST_RUN: begin
            outValid = (index >= chunkW);
            outLast  = allRecv && (index == chunkW);
         end
         ST_FLUSH: begin
            outValid = (index != '0);
            outLast  = (index != '0);
         end
         default: ;
      endcase
   end

   unpack_buffer buffer (
      .clk     (clk),
      .rst     (rst),
      .insert  (insert),
      .insData (DRAMreadData),
      .pop     (pop),
      .narrow  (narrowReg),
      .head    (head),
      .index   (index)
   );

   // Run control: clearing the in-flight tags on reset is what makes late read data harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         baseReg     <= '0;
         numReg      <= '0;
         wordsIssued <= '0;
         wordsRecv   <= '0;
         narrowReg   <= 1'b0;
         inflight    <= '0;
      end else begin
         inflight <= RD_LAT'({inflight, DRAMreadEn});
         if (DRAMreadEn) wordsIssued <= wordsIssued + 1'b1;
         if (insert) wordsRecv <= wordsRecv + 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  baseReg     <= baseAddr;
                  numReg      <= {1'b0, numWords};
                  narrowReg   <= chunkSel;
                  wordsIssued <= '0;
                  wordsRecv   <= '0;
                  state       <= (numWords == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (allRecv) begin
                  if ((pop && outLast) || (index == '0)) state <= ST_DONE;
                  else if (index < chunkW) state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (pop) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_in_unpack.sv
// Directed bench for fifo_in_unpack: a bit-stream model predicts the chunk sequence and read addresses.
`timescale 1ns/1ps
module tb_fifo_in_unpack;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] baseAddr = '0;
   logic [ADDR_W-1:0] numWords = '0;
   logic              chunkSel = 1'b0;
   logic              DRAMreadEn;
   logic [ADDR_W-1:0] DRAMreadAddr;
   logic [63:0]       DRAMreadData = '0;
   logic [63:0]       outData;
   logic              outValid;
   logic              outReady = 1'b1;
   logic              outLast;
   logic              busy;
   logic              done;

   int checks = 0;
   int failures = 0;
   logic [63:0]       expQ[$];
   logic [ADDR_W-1:0] addrQ[$];
   int readsIssued = 0;
   int transfers = 0;
   int cyc = 0;
   int lastXferCyc = 0;
   int doneCyc = 0;
   int startCyc = 0;
   bit monitorOn = 1'b0;
   bit prevStall = 1'b0;
   logic [63:0] prevData = '0;
   logic [ADDR_W-1:0] dramAddr;

   fifo_in_unpack #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .baseAddr     (baseAddr),
      .numWords     (numWords),
      .chunkSel     (chunkSel),
      .DRAMreadEn   (DRAMreadEn),
      .DRAMreadAddr (DRAMreadAddr),
      .DRAMreadData (DRAMreadData),
      .outData      (outData),
      .outValid     (outValid),
      .outReady     (outReady),
      .outLast      (outLast),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Each 16-bit lane carries the address so chunk boundaries are easy to read by eye.
   function automatic logic [63:0] memWord(input logic [ADDR_W-1:0] a);
      logic [15:0] a16;
      a16 = {6'b0, a};
      return {16'hD000 | a16, 16'hC000 | a16, 16'hB000 | a16, 16'hA000 | a16};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: concatenate the words into one bit stream and cut it into w-bit chunks, padding the last.
   task automatic buildModel(input logic [ADDR_W-1:0] base, input int n, input bit narrow);
      bit bits[$];
      int w;
      logic [63:0] word;
      logic [63:0] chunk;
      w = narrow ? 48 : 64;
      expQ.delete();
      addrQ.delete();
      for (int i = 0; i < n; i++) begin
         word = memWord(base + ADDR_W'(i));
         addrQ.push_back(base + ADDR_W'(i));
         for (int b = 0; b < 64; b++) bits.push_back(word[b]);
      end
      while (bits.size() > 0) begin
         chunk = '0;
         for (int j = 0; j < w; j++) if (bits.size() > 0) chunk[j] = bits.pop_front();
         expQ.push_back(chunk);
      end
   endtask

   // DRAM: address checked on request, data presented for the whole following cycle.
   initial forever begin
      @(negedge clk);
      if (DRAMreadEn === 1'b1) begin
         dramAddr = DRAMreadAddr;
         readsIssued++;
         if (addrQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL extraRead actual=%h required=none", dramAddr);
         end else begin
            check("readAddr", 64'(dramAddr), 64'(addrQ[0]));
            void'(addrQ.pop_front());
         end
         @(posedge clk);
         #1 DRAMreadData = memWord(dramAddr);
      end
   end

   // Compare process: every transfer against the model, and held data during stalls.
   initial forever begin
      @(negedge clk);
      if (monitorOn && !rst) begin
         if (prevStall) check("holdData", outData, prevData);
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL extraChunk actual=%h required=none", outData);
            end else begin
               check("chunkData", outData, expQ[0]);
               check("chunkLast", 64'(outLast), 64'(expQ.size() == 1));
               void'(expQ.pop_front());
            end
            transfers++;
            lastXferCyc = cyc;
         end
         prevStall = outValid && !outReady;
         prevData = outData;
      end else begin
         prevStall = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int n, input bit narrow, input int stall);
      int readsBefore;
      bit got;
      transfers = 0;
      @(posedge clk);
      #1;
      baseAddr = base;
      numWords = ADDR_W'(n);
      chunkSel = narrow;
      outReady = (stall == 0);
      start = 1'b1;
      readsBefore = readsIssued;
      @(posedge clk);
      #1;
      start = 1'b0;
      startCyc = cyc;
      if (n > 0) check("busyAfterStart", 64'(busy), 64'(1));
      if (stall > 0) begin
         repeat (stall) @(posedge clk);
         @(negedge clk);
         check("stallReads", 64'(readsIssued - readsBefore), 64'(2));
         check("stallNoRead", 64'(DRAMreadEn), 64'(0));
         @(posedge clk);
         #1 outReady = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            doneCyc = cyc;
            break;
         end
      end
      check("doneSeen", 64'(got), 64'(1));
   endtask

   task automatic checkOutput(input int expChunks, input bit nonEmpty);
      check("chunksLeft", 64'(expQ.size()), 64'(0));
      check("readsLeft", 64'(addrQ.size()), 64'(0));
      check("chunkCount", 64'(transfers), 64'(expChunks));
      if (nonEmpty) check("doneAfterLast", 64'(doneCyc), 64'(lastXferCyc + 1));
      @(negedge clk);
      check("donePulse", 64'(done), 64'(0));
      check("busyIdle", 64'(busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rstCtrl", 64'({outValid, outLast, busy, done, DRAMreadEn}), 64'(0));
      check("rstData", outData, 64'(0));
      check("rstAddr", 64'(DRAMreadAddr), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      monitorOn = 1'b1;

      $display("[TB] wide run, 4 words from 0x010");
      buildModel(10'h010, 4, 1'b0);
      check("pinWide3", expQ[3], 64'hD013_C013_B013_A013);
      applyStimulus(10'h010, 4, 1'b0, 0);
      checkOutput(4, 1'b1);

      $display("[TB] narrow run, 3 words");
      buildModel(10'h010, 3, 1'b1);
      check("pinNarrow0", expQ[0], 64'h0000_C010_B010_A010);
      check("pinNarrow1", expQ[1], 64'h0000_B011_A011_D010);
      check("pinNarrow2", expQ[2], 64'h0000_A012_D011_C011);
      check("pinNarrow3", expQ[3], 64'h0000_D012_C012_B012);
      applyStimulus(10'h010, 3, 1'b1, 0);
      checkOutput(4, 1'b1);

      $display("[TB] narrow tail, 1 word");
      buildModel(10'h020, 1, 1'b1);
      check("pinTail0", expQ[0], 64'h0000_C020_B020_A020);
      check("pinTail1", expQ[1], 64'h0000_0000_0000_D020);
      applyStimulus(10'h020, 1, 1'b1, 0);
      checkOutput(2, 1'b1);

      $display("[TB] backpressure, 6 wide words");
      buildModel(10'h080, 6, 1'b0);
      applyStimulus(10'h080, 6, 1'b0, 20);
      checkOutput(6, 1'b1);

      $display("[TB] narrow run across address wrap");
      buildModel(10'h3FE, 4, 1'b1);
      applyStimulus(10'h3FE, 4, 1'b1, 0);
      checkOutput(6, 1'b1);

      $display("[TB] narrow run, 5 words");
      buildModel(10'h100, 5, 1'b1);
      applyStimulus(10'h100, 5, 1'b1, 0);
      checkOutput(7, 1'b1);

      $display("[TB] reset mid-run");
      buildModel(10'h040, 8, 1'b0);
      @(posedge clk);
      #1;
      baseAddr = 10'h040;
      numWords = 10'd8;
      chunkSel = 1'b0;
      outReady = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 50 && cnt < 2; i++) begin
         @(negedge clk);
         if (DRAMreadEn) cnt++;
      end
      check("secondRead", 64'(cnt), 64'(2));
      @(posedge clk);
      #1;
      monitorOn = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midRstCtrl", 64'({outValid, outLast, busy, done, DRAMreadEn}), 64'(0));
      check("midRstData", outData, 64'(0));
      check("midRstAddr", 64'(DRAMreadAddr), 64'(0));
      expQ.delete();
      addrQ.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("postRstIdle", 64'({outValid, busy, DRAMreadEn}), 64'(0));
      end
      monitorOn = 1'b1;
      buildModel(10'h050, 3, 1'b0);
      applyStimulus(10'h050, 3, 1'b0, 0);
      checkOutput(3, 1'b1);

      $display("[TB] empty run");
      buildModel(10'h100, 0, 1'b0);
      applyStimulus(10'h100, 0, 1'b0, 0);
      check("emptyDoneLatency", 64'(doneCyc - startCyc <= 1), 64'(1));
      checkOutput(0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
